imem_program_loader: RTL and testbench

//  Byte-stream writer for the 64-word instruction memory.

---
 rtl/mips32_loader_pkg.sv | 19 +
 rtl/imem_program_loader_if.sv | 30 +++
 rtl/loader_word_assembler.sv | 30 +++
 rtl/imem_program_loader.sv | 124 ++++++++++++
 tb/tb_imem_program_loader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory program loader.
// The IMEM geometry constants are also used by instruction_memory.
package mips32_loader_pkg;

  localparam int         LOADER_IMEM_DEPTH  = 64;
  localparam int         LOADER_ADDR_W      = $clog2(LOADER_IMEM_DEPTH);
  localparam logic [7:0] LOADER_SYNC_BYTE   = 8'hA5;
  localparam int         LOADER_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } loader_state_e;

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream input link plus IMEM write port and loader status, bundled for the loader.
// master = stream source / system side, slave = the loader.
interface imem_program_loader_if
  import mips32_loader_pkg::*;
#(
  parameter int ADDR_W = LOADER_ADDR_W
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   words_loaded;

  modport master (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
    input  cpu_hold, load_done, load_error, words_loaded
  );

  modport slave (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata,
    output cpu_hold, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/loader_word_assembler.sv
// Collects payload bytes big-endian into 32-bit words; word_valid_o fires
// combinationally on the handshake of the 4th byte of each word.
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [23:0] shift_q;
  logic [1:0]  idx_q;

  assign word_valid_o = byte_valid_i & (idx_q == 2'd3);
  assign word_o       = {shift_q, byte_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (clear_i) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      idx_q   <= idx_q + 2'd1;
    end
  end
endmodule

// File: rtl/imem_program_loader.sv
// Frame-based byte-stream loader for the instruction memory; holds the CPU while loading.
// Define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module imem_program_loader
  import mips32_loader_pkg::*;
#(
  parameter int         IMEM_DEPTH  = LOADER_IMEM_DEPTH,
  parameter int         ADDR_W      = LOADER_ADDR_W,
  parameter logic [7:0] SYNC_BYTE   = LOADER_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = LOADER_TIMEOUT_CYC
) (
  input logic                  clk,
  input logic                  reset_n,
  imem_program_loader_if.slave bus
);
  localparam int GAP_W = $clog2(TIMEOUT_CYC + 1);

  loader_state_e     state_q, state_d;
  logic              rx_ready_q, imem_we_q, cpu_hold_q, load_done_q, load_error_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic [ADDR_W:0]   words_q, count_q;
  logic [GAP_W-1:0]  gap_q;

  logic        hs, sync_hs, in_frame, timeout_hit, count_ok;
  logic        byte_in, last_word, asm_clear, asm_valid;
  logic [31:0] asm_word;

  assign hs          = bus.rx_valid & rx_ready_q;
  assign sync_hs     = hs & (state_q == ST_IDLE) & (bus.rx_data == SYNC_BYTE);
  assign in_frame    = (state_q == ST_COUNT) | (state_q == ST_DATA) | (state_q == ST_CHECK);
  assign timeout_hit = in_frame & ~hs & (gap_q == GAP_W'(TIMEOUT_CYC - 1));
  assign count_ok    = (bus.rx_data != 8'd0) && (int'(bus.rx_data) <= IMEM_DEPTH);
  assign byte_in     = hs & (state_q == ST_DATA);
  assign last_word   = asm_valid & ((words_q + 1'b1) == count_q);
  assign asm_clear   = sync_hs | (state_d == ST_ERROR);

  loader_word_assembler u_asm (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (asm_clear),
    .byte_valid_i (byte_in),
    .byte_i       (bus.rx_data),
    .word_valid_o (asm_valid),
    .word_o       (asm_word)
  );

`ifdef LOADER_CHECKSUM_EN
  localparam loader_state_e AFTER_PAYLOAD = ST_CHECK;
  logic [7:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     csum_q <= '0;
    else if (sync_hs) csum_q <= '0;
    else if (byte_in) csum_q <= csum_q ^ bus.rx_data;
  end
`else
  localparam loader_state_e AFTER_PAYLOAD = ST_DONE;
`endif

  always_comb begin
    // NOTE: state_d gets its default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (sync_hs)   state_d = ST_COUNT;
      ST_COUNT: if (hs)        state_d = count_ok ? ST_DATA : ST_ERROR;
      ST_DATA:  if (last_word) state_d = AFTER_PAYLOAD;
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK: if (hs)        state_d = (bus.rx_data == csum_q) ? ST_DONE : ST_ERROR;
`endif
      default:                 state_d = ST_IDLE; // DONE and ERROR last one cycle
    endcase
    if (timeout_hit) state_d = ST_ERROR;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_hold_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
      words_q      <= '0;
      count_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q     <= state_d;
      // Registered flags follow the state being entered, so they line up with it.
      rx_ready_q  <= (state_d != ST_DONE) && (state_d != ST_ERROR);
      cpu_hold_q  <= (state_d != ST_IDLE);
      load_done_q <= (state_d == ST_DONE);
      imem_we_q   <= asm_valid;
      gap_q       <= (hs || !in_frame) ? '0 : gap_q + 1'b1;

      if (hs && (state_q == ST_COUNT)) begin
        count_q     <= bus.rx_data[ADDR_W:0];
        imem_addr_q <= '0;
      end
      if (asm_valid) begin
        imem_wdata_q <= asm_word;
        imem_addr_q  <= words_q[ADDR_W-1:0];
        words_q      <= words_q + 1'b1;
      end
      if (sync_hs) begin
        words_q      <= '0;
        load_error_q <= 1'b0;
      end else if (state_d == ST_ERROR) begin
        load_error_q <= 1'b1;
      end
    end
  end

  assign bus.rx_ready     = rx_ready_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = imem_addr_q;
  assign bus.imem_wdata   = imem_wdata_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.load_done    = load_done_q;
  assign bus.load_error   = load_error_q;
  assign bus.words_loaded = words_q;
endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: frame-level reference model pushes expected
// writes and frame outcomes; a negedge monitor pops and compares them.
module tb_imem_program_loader;
  import mips32_loader_pkg::*;

  localparam int T = LOADER_TIMEOUT_CYC;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit ok;
    int words;
  } end_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  imem_program_loader_if bus ();

  imem_program_loader dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  wr_t         exp_wr[$];
  end_t        exp_end[$];
  logic [31:0] dir_words[$];
  logic [31:0] mem_exp[64];
  logic [31:0] mem_seen[64];
  int          tests_run = 0;
  int          tests_failed = 0;
  bit          err_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s", name);
  endtask

  // Monitor: compare every IMEM write and every frame outcome against the scoreboard.
  always @(negedge clk) begin
    wr_t  w;
    end_t e;
    if (reset_n) begin
      if (bus.imem_we) begin
        if (exp_wr.size() == 0) fail_now("unexpected imem write");
        else begin
          w = exp_wr.pop_front();
          check("write addr", 32'(bus.imem_addr), 32'(w.addr));
          check("write data", bus.imem_wdata, w.data);
          check("cpu_hold during write", 32'(bus.cpu_hold), 32'd1);
        end
        mem_seen[bus.imem_addr] = bus.imem_wdata;
      end
      if (bus.load_done || (bus.load_error && !err_prev)) begin
        if (exp_end.size() == 0) fail_now("unexpected frame end");
        else begin
          e = exp_end.pop_front();
          check("frame ok", 32'(bus.load_done), 32'(e.ok));
          check("words_loaded", 32'(bus.words_loaded), 32'(e.words));
          check("rx_ready low at frame end", 32'(bus.rx_ready), 32'd0);
          check("cpu_hold at frame end", 32'(bus.cpu_hold), 32'd1);
        end
      end
    end
    err_prev = bus.load_error;
  end

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    while (!bus.rx_ready) begin
      guard++;
      if (guard > 100) begin
        fail_now("rx_ready never asserted");
        return;
      end
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic wait_end(input int budget);
    int c = 0;
    while (exp_end.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_end.size() != 0) begin
      fail_now("frame end not seen within budget");
      exp_end.delete();
    end
  endtask

  // Frame-level model: n = count byte, cut >= 0 stops after that many payload bytes
  // (then the link idles into a timeout), bad_ck corrupts the checksum byte,
  // long_gap_idx puts a T-1 cycle pause before that payload byte.
  task automatic do_frame(input logic [7:0] n, input int cut, input bit bad_ck,
                          input int max_gap, input int long_gap_idx);
    logic [7:0]  bytes[$];
    logic [31:0] words[$];
    logic [31:0] w;
    logic [7:0]  ck = 8'h00;
    logic [7:0]  junk;
    bit          valid;
    int          nw, sent, full;
    end_t        e;
    wr_t         x;

    valid = (n != 8'd0) && (int'(n) <= LOADER_IMEM_DEPTH);
    nw    = valid ? int'(n) : 0;
    for (int i = 0; i < nw; i++) begin
      w = (dir_words.size() > 0) ? dir_words.pop_front() : $urandom;
      words.push_back(w);
      bytes.push_back(w[31:24]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
    end
    dir_words.delete();
    foreach (bytes[i]) ck = ck ^ bytes[i];
    sent = (cut < 0) ? bytes.size() : cut;
    full = sent / 4;
    for (int i = 0; i < full; i++) begin
      x.addr = 6'(i);
      x.data = words[i];
      exp_wr.push_back(x);
      mem_exp[i] = words[i];
    end
    if (!valid)                   begin e.ok = 1'b0; e.words = 0;    end
    else if (cut >= 0)            begin e.ok = 1'b0; e.words = full; end
    else if (CK_EN && bad_ck)     begin e.ok = 1'b0; e.words = nw;   end
    else                          begin e.ok = 1'b1; e.words = nw;   end
    exp_end.push_back(e);

    repeat ($urandom_range(0, 2)) begin
      junk = 8'($urandom);
      if (junk == LOADER_SYNC_BYTE) junk = 8'h5A;
      send_byte(junk);
    end
    send_byte(LOADER_SYNC_BYTE);
    check("load_error cleared by sync", 32'(bus.load_error), 32'd0);
    check("cpu_hold after sync", 32'(bus.cpu_hold), 32'd1);
    send_byte(n);
    if (valid) begin
      for (int i = 0; i < sent; i++) begin
        if (i == long_gap_idx) idle(T - 1);
        else idle($urandom_range(0, max_gap));
        send_byte(bytes[i]);
      end
      if (cut < 0 && CK_EN) send_byte(bad_ck ? (ck ^ 8'h08) : ck);
    end
    wait_end((cut >= 0) ? T + 50 : 50);
    check("writes drained", 32'(exp_wr.size()), 32'd0);
    idle(2);
    check("cpu_hold released", 32'(bus.cpu_hold), 32'd0);
    check("rx_ready in IDLE", 32'(bus.rx_ready), 32'd1);
    check("load_error level", 32'(bus.load_error), e.ok ? 32'd0 : 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rx_ready"},     32'(bus.rx_ready),     32'd0);
    check({tag, " imem_we"},      32'(bus.imem_we),      32'd0);
    check({tag, " imem_addr"},    32'(bus.imem_addr),    32'd0);
    check({tag, " imem_wdata"},   bus.imem_wdata,        32'd0);
    check({tag, " cpu_hold"},     32'(bus.cpu_hold),     32'd0);
    check({tag, " load_done"},    32'(bus.load_done),    32'd0);
    check({tag, " load_error"},   32'(bus.load_error),   32'd0);
    check({tag, " words_loaded"}, 32'(bus.words_loaded), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    logic [7:0] n;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    foreach (mem_exp[i]) begin
      mem_exp[i]  = 32'h0;
      mem_seen[i] = 32'h0;
    end

    idle(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    idle(2);
    check("rx_ready after reset", 32'(bus.rx_ready), 32'd1);

    // Two-word program.
    dir_words = '{32'h2008_0005, 32'h2009_0007};
    do_frame(8'd2, -1, 1'b0, 0, -1);
    // Zero and oversized word counts.
    do_frame(8'd0, -1, 1'b0, 0, -1);
    do_frame(8'h41, -1, 1'b0, 0, -1);
`ifdef LOADER_CHECKSUM_EN
    dir_words = '{32'h1234_5678};
    do_frame(8'd1, -1, 1'b1, 0, -1);
`endif
    // Timeout after two payload bytes; the next sync clears load_error.
    dir_words = '{32'h1234_5678};
    do_frame(8'd1, 2, 1'b0, 0, -1);
    // Full 64-word image and a pause just short of the timeout.
    do_frame(8'd64, -1, 1'b0, 1, -1);
    do_frame(8'd1, -1, 1'b0, 0, 3);

    // Reset in the middle of a frame.
    send_byte(LOADER_SYNC_BYTE);
    send_byte(8'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    check("cpu_hold before mid-frame reset", 32'(bus.cpu_hold), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("mid-frame reset");
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);
    dir_words = '{32'hDEAD_BEEF, 32'h0BAD_F00D};
    do_frame(8'd2, -1, 1'b0, 0, -1);

    for (int r = 0; r < 20; r++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255));
        do_frame(n, -1, 1'b0, 3, -1);
      end else if (kind == 1) begin
        n = 8'($urandom_range(1, 6));
        do_frame(n, $urandom_range(0, 4 * int'(n) - 1), 1'b0, 3, -1);
      end else if (kind == 2) begin
        do_frame(8'($urandom_range(1, 8)), -1, 1'b1, 3, -1);
      end else begin
        do_frame(8'($urandom_range(1, 12)), -1, 1'b0, 3, -1);
      end
    end

    check("no leftover writes", 32'(exp_wr.size()), 32'd0);
    check("no leftover frame ends", 32'(exp_end.size()), 32'd0);
    for (int i = 0; i < 64; i++) check("imem contents", mem_seen[i], mem_exp[i]);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
